// File: rtl/ntt_pkg.sv
// Shared NTT parameters, controller FSM state type and the bank command payload
// carried from the issue side to the write side.
package ntt_pkg;

  localparam int unsigned DATA_W = 28;
  localparam logic [DATA_W-1:0] NTT_Q = 28'd268369921;  // 2^28 - 2^16 + 1
  localparam int unsigned N = 1024;
  localparam int unsigned P = 32;
  localparam int unsigned NUM_ROWS = N / (2 * P);
  localparam int unsigned NUM_STAGES = $clog2(N);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned STAGE_W = 4;
  localparam int unsigned TW_W = STAGE_W + ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              bank;
  } bank_cmd_t;

  // Counter width for a count of n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// Control bundle between the NTT stage controller, its host and the coefficient banks.
interface ntt_stage_ctrl_if;
  import ntt_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic [TW_W-1:0]   tw_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank;
  logic [STAGE_W-1:0] stage;

  // Controller side: takes the request, drives bank strobes and status.
  modport master (
    input  start,
    output busy, done, rd_en, rd_addr, rd_bank, tw_addr, wr_en, wr_addr, wr_bank, stage
  );

  // Host / bank side.
  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr, rd_bank, tw_addr, wr_en, wr_addr, wr_bank, stage
  );

endinterface

// File: rtl/ntt_stage_ctrl_delay.sv
// Fixed-latency register chain that replays issued bank commands on the write side,
// matching the butterfly array latency; synchronous clear empties the whole chain.
module ctrl_delay
  import ntt_pkg::*;
#(
  parameter int unsigned DEPTH = 7
) (
  input  logic      clk,
  input  logic      clr,
  input  bank_cmd_t issue_cmd,
  output bank_cmd_t write_cmd
);

  bank_cmd_t chain_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      chain_q[0] <= issue_cmd;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign write_cmd = chain_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// NTT stage sequencer: issues NUM_ROWS butterfly reads per stage, drains the butterfly
// pipeline for BF_LAT cycles, ping-pongs banks between stages and pulses done at the end.
module ntt_stage_ctrl #(
  parameter int unsigned NUM_ROWS   = ntt_pkg::NUM_ROWS,
  parameter int unsigned NUM_STAGES = ntt_pkg::NUM_STAGES,
  parameter int unsigned BF_LAT     = 7
) (
  input logic              clk,
  input logic              rst,
  ntt_stage_ctrl_if.master bus
);
  import ntt_pkg::*;

  localparam int unsigned ROW_W = cnt_width(NUM_ROWS);
  localparam int unsigned STG_W = cnt_width(NUM_STAGES);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(NUM_ROWS - 1);
  localparam logic [STG_W-1:0] STG_LAST   = STG_W'(NUM_STAGES - 1);
  localparam logic [4:0]       DRAIN_LAST = 5'(BF_LAT - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [4:0]       drain_q, drain_d;

  logic               issuing;
  logic [ADDR_W-1:0]  row_ext;
  logic [STAGE_W-1:0] stage_ext;
  bank_cmd_t          issue_cmd;
  bank_cmd_t          write_cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    stage_d = stage_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StIssue;
          row_d   = '0;
          stage_d = '0;
        end
      end
      StIssue: begin
        // Row parks on its terminal value until the next stage clears it.
        if (row_q == ROW_LAST) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == STG_LAST) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            stage_d = stage_q + 1'b1;
            row_d   = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign issuing   = (state_q == StIssue);
  assign row_ext   = ADDR_W'(row_q);
  assign stage_ext = STAGE_W'(stage_q);

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.stage   = stage_ext;
  assign bus.rd_en   = issuing;
  assign bus.rd_bank = stage_ext[0];
  assign bus.rd_addr = issuing ? row_ext : '0;
  assign bus.tw_addr = issuing ? {stage_ext, row_ext} : '0;

  // Bank is gated by en so idle slots travel down the chain as all-zero commands.
  always_comb begin
    issue_cmd      = '0;
    issue_cmd.en   = issuing;
    issue_cmd.addr = bus.rd_addr;
    issue_cmd.bank = issuing & ~stage_ext[0];
  end

  ctrl_delay #(
    .DEPTH(BF_LAT)
  ) u_delay (
    .clk       (clk),
    .clr       (rst),
    .issue_cmd (issue_cmd),
    .write_cmd (write_cmd)
  );

  assign bus.wr_en   = write_cmd.en;
  assign bus.wr_addr = write_cmd.addr;
  assign bus.wr_bank = write_cmd.bank;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: a default instance and a tiny one
// (BF_LAT=1, NUM_ROWS=2, NUM_STAGES=1) share start/rst; expected events come from a timing model.
module tb_ntt_stage_ctrl;

  typedef struct packed {
    int         cyc;
    logic [3:0] addr;
    logic       bank;
    logic [7:0] tw;
    logic [3:0] stage;
  } ev_t;

  localparam int R1 = 2;
  localparam int S1 = 1;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;

  int nr [2];
  int ns [2];
  int lat [2];
  int blo [2];
  int bhi [2];
  int idle_after [2];
  int n_rd [2];
  int n_wr [2];
  ev_t rd_q [2][$];
  ev_t wr_q [2][$];
  int  done_q [2][$];

  ntt_stage_ctrl_if bus0 ();
  ntt_stage_ctrl_if bus1 ();
  assign bus0.start = start_s;
  assign bus1.start = start_s;

  ntt_stage_ctrl u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  ntt_stage_ctrl #(
    .NUM_ROWS   (R1),
    .NUM_STAGES (S1),
    .BF_LAT     (L1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, d, cyc + 1, act, exp);
    end
  endtask

  // A transform accepted at edge e: stage s row r is read at e+1+s*(rows+lat)+r,
  // written lat cycles later to the opposite bank; done follows the last drain.
  task automatic model_start(input int d, input int e);
    int  per;
    ev_t ev;
    per = nr[d] + lat[d];
    for (int s = 0; s < ns[d]; s++) begin
      for (int r = 0; r < nr[d]; r++) begin
        ev.cyc   = e + 1 + s * per + r;
        ev.addr  = 4'(r);
        ev.bank  = 1'(s % 2);
        ev.tw    = 8'(s * 16 + r);
        ev.stage = 4'(s);
        rd_q[d].push_back(ev);
        ev.cyc  = ev.cyc + lat[d];
        ev.bank = ~ev.bank;
        wr_q[d].push_back(ev);
      end
    end
    blo[d] = e + 1;
    bhi[d] = e + 1 + ns[d] * per;
    done_q[d].push_back(bhi[d]);
    idle_after[d] = bhi[d];
  endtask

  task automatic model_reset(input int d, input int e);
    while (rd_q[d].size() > 0 && rd_q[d][$].cyc > e) void'(rd_q[d].pop_back());
    while (wr_q[d].size() > 0 && wr_q[d][$].cyc > e) void'(wr_q[d].pop_back());
    while (done_q[d].size() > 0 && done_q[d][$] > e) void'(done_q[d].pop_back());
    if (bhi[d] > e) bhi[d] = e;
    idle_after[d] = e;
  endtask

  task automatic step(input logic st, input logic rs);
    start_s = st;
    rst     = rs;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rs) model_reset(d, cyc);
      else if (st && cyc > idle_after[d]) model_start(d, cyc);
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((cyc <= idle_after[0] || cyc <= idle_after[1]) && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
  endtask

  task automatic mon(input int d, input logic busy, input logic done, input logic rd_en,
                     input logic [3:0] rd_addr, input logic rd_bank, input logic [7:0] tw_addr,
                     input logic wr_en, input logic [3:0] wr_addr, input logic wr_bank,
                     input logic [3:0] stage);
    int   c;
    logic exp_v;
    ev_t  ev;
    c = cyc + 1;
    chk("busy", d, 32'(busy), 32'(c >= blo[d] && c <= bhi[d]));

    exp_v = (rd_q[d].size() > 0 && rd_q[d][0].cyc == c);
    chk("rd_en", d, 32'(rd_en), 32'(exp_v));
    if (rd_en) n_rd[d]++;
    if (exp_v) begin
      ev = rd_q[d].pop_front();
      if (rd_en) begin
        chk("rd_addr", d, 32'(rd_addr), 32'(ev.addr));
        chk("rd_bank", d, 32'(rd_bank), 32'(ev.bank));
        chk("tw_addr", d, 32'(tw_addr), 32'(ev.tw));
        chk("stage", d, 32'(stage), 32'(ev.stage));
      end
    end
    if (!rd_en) chk("rd_idle_addr", d, 32'({rd_addr, tw_addr}), 32'(0));

    exp_v = (wr_q[d].size() > 0 && wr_q[d][0].cyc == c);
    chk("wr_en", d, 32'(wr_en), 32'(exp_v));
    if (wr_en) n_wr[d]++;
    if (exp_v) begin
      ev = wr_q[d].pop_front();
      if (wr_en) begin
        chk("wr_addr", d, 32'(wr_addr), 32'(ev.addr));
        chk("wr_bank", d, 32'(wr_bank), 32'(ev.bank));
      end
    end
    if (rd_en && wr_en) chk("bank_clash", d, 32'(rd_bank == wr_bank), 32'(0));

    exp_v = (done_q[d].size() > 0 && done_q[d][0] == c);
    chk("done", d, 32'(done), 32'(exp_v));
    if (exp_v) void'(done_q[d].pop_front());
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0, bus0.busy, bus0.done, bus0.rd_en, bus0.rd_addr, bus0.rd_bank, bus0.tw_addr,
          bus0.wr_en, bus0.wr_addr, bus0.wr_bank, bus0.stage);
      mon(1, bus1.busy, bus1.done, bus1.rd_en, bus1.rd_addr, bus1.rd_bank, bus1.tw_addr,
          bus1.wr_en, bus1.wr_addr, bus1.wr_bank, bus1.stage);
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, 0, 32'({bus0.busy, bus0.done, bus0.rd_en, bus0.rd_addr, bus0.rd_bank,
                      bus0.tw_addr, bus0.wr_en, bus0.wr_addr, bus0.wr_bank, bus0.stage}), 32'(0));
    chk(name, 1, 32'({bus1.busy, bus1.done, bus1.rd_en, bus1.rd_addr, bus1.rd_bank,
                      bus1.tw_addr, bus1.wr_en, bus1.wr_addr, bus1.wr_bank, bus1.stage}), 32'(0));
  endtask

  initial begin
    int base_rd;
    int base_wr;
    int c0;
    nr[0] = 16; ns[0] = 10; lat[0] = 7;
    nr[1] = R1; ns[1] = S1; lat[1] = L1;
    for (int d = 0; d < 2; d++) begin
      blo[d] = 1; bhi[d] = 0; idle_after[d] = -1; n_rd[d] = 0; n_wr[d] = 0;
    end

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    mon_on = 1'b1;

    // Single start pulse: full default transform and the tiny one in parallel.
    base_rd = n_rd[0];
    base_wr = n_wr[0];
    step(1'b1, 1'b0);
    run_idle(400);
    chk("rd_count", 0, 32'(n_rd[0] - base_rd), 32'(nr[0] * ns[0]));
    chk("wr_count", 0, 32'(n_wr[0] - base_wr), 32'(nr[0] * ns[0]));

    // Start held high well past the first done.
    repeat (240) step(1'b1, 1'b0);
    run_idle(400);

    // Reset 100 cycles into a transform, quiet period, then a fresh transform.
    step(1'b1, 1'b0);
    c0 = cyc;
    while (cyc < c0 + 99) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    @(negedge clk);
    chk_all_zero("mid_reset_outputs");
    repeat (40) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    run_idle(400);

    // Random start/reset traffic.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 199) == 0));
    end
    run_idle(400);
    step(1'b0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      chk("rd_pending", d, 32'(rd_q[d].size()), 32'(0));
      chk("wr_pending", d, 32'(wr_q[d].size()), 32'(0));
      chk("done_pending", d, 32'(done_q[d].size()), 32'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ntt_stage_ctrl.md
NTT_STAGE_CTRL -- requirements
Module: ntt_stage_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 16, meaning butterfly issue cycles per stage (N/(2P) for N=1024, P=32).
REQ-002 SHALL have parameter NUM_STAGES, default 10, meaning stages per transform (log2 N).
REQ-003 SHALL have parameter BF_LAT, default 7, meaning butterfly array input-to-output latency in cycles; legal range 1..31.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  input  1  transform request, sampled only in IDLE.
REQ-007 SHALL have port busy  output  1  high from the first ISSUE cycle through the DONE cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the last write of the last stage has completed.
REQ-009 SHALL have port rd_en  output  1  read strobe to the coefficient banks and butterfly inputs.
REQ-010 SHALL have port rd_addr  output  4  row index being read.
REQ-011 SHALL have port rd_bank  output  1  source bank, equal to stage[0].
REQ-012 SHALL have port tw_addr  output  8  twiddle ROM address {stage[3:0], row[3:0]}, aligned with rd_en.
REQ-013 SHALL have port wr_en  output  1  write strobe for butterfly results.
REQ-014 SHALL have port wr_addr  output  4  destination row.
REQ-015 SHALL have port wr_bank  output  1  destination bank, the inverse of the rd_bank with which the row was issued.
REQ-016 SHALL have port stage  output  4  current stage, 0..NUM_STAGES-1.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-018 SHALL transition IDLE->ISSUE on start=1; stage and row are cleared on that edge.
REQ-019 SHALL, in ISSUE, assert rd_en each cycle with rd_addr = row, and increment row from 0 to NUM_ROWS-1, then enter DRAIN.
REQ-020 SHALL remain in DRAIN for exactly BF_LAT cycles, so the last write of the stage completes before the next stage reads.
REQ-021 SHALL, at DRAIN exit: if stage < NUM_STAGES-1, increment stage, clear row and enter ISSUE; otherwise enter DONE.
REQ-022 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL reproduce wr_en, wr_addr and wr_bank as rd_en, rd_addr and ~rd_bank delayed by exactly BF_LAT cycles.
REQ-024 SHALL hold rd_addr and tw_addr at 0 whenever rd_en=0.
REQ-025 SHALL give a start-to-done time of 1 + NUM_STAGES*(NUM_ROWS+BF_LAT) cycles; with defaults, done is high at cycle 231, where cycle 0 is the start edge.
REQ-026 SHALL ignore start while busy=1 and while in DONE.
REQ-027 SHALL keep row and stage counters exact-width, with no wrap beyond their terminal values.
REQ-028 SHALL issue stage s rows at cycles 1+s*23 .. 16+s*23 with defaults.

Reset
REQ-029 SHALL, on rst=1, force state IDLE, clear stage and row, and drive busy, done, rd_en, rd_addr, rd_bank, tw_addr, wr_en, wr_addr and wr_bank to 0 on the next edge.
REQ-030 SHALL clear the whole write-delay pipeline on reset, so a reset mid-transform produces no stale wr_en afterwards.
REQ-031 SHALL give rst priority over start in the same cycle.

Structure
REQ-032 SHALL take NTT_Q (2^28-2^16+1), DATA_W=28, N=1024, P=32, NUM_ROWS, NUM_STAGES and the FSM state enum from shared package ntt_pkg.
REQ-033 SHALL implement the write-side alignment in one sub-module, ctrl_delay: a parameterised BF_LAT-deep register chain for {en, addr, bank} with synchronous clear.

Verification
REQ-034 SHALL cover: start pulse at cycle 0 with defaults -> busy 1..231, done only at 231, exactly 160 rd_en and 160 wr_en cycles.
REQ-035 SHALL cover: stage 0 -> rd_en at cycles 1..16 with rd_addr 0..15 and tw_addr 0x00..0x0F; wr_en at 8..23 with wr_bank=1.
REQ-036 SHALL cover: stage 1 -> rd_en at cycle 24, rd_bank=1, tw_addr=0x10; no cycle where rd_en and a same-stage wr_en to the same bank overlap.
REQ-037 SHALL cover: start held high through the whole run -> only one transform; a new one begins only from the start sampled in IDLE after done.
REQ-038 SHALL cover: rst asserted at cycle 100 -> all outputs 0 at cycle 101, no wr_en for the next 40 cycles, and a fresh start completes in 231 cycles.
REQ-039 SHALL cover: BF_LAT=1, NUM_ROWS=2, NUM_STAGES=1 -> done at cycle 4, wr_en at cycles 2..3.
